branch_predict_tournament: RTL and testbench
============================================

// Module: branch_predict_tournament
// PURPOSE
//  Parametrised tournament branch predictor for the 5-stage MIPS pipeline (IF|ID|EX|MEM|WB).
//  Two components predict in IF from pcF: a local two-level predictor (per-PC history BHT -> LPHT)
//  and a gshare global predictor (GHR ^ PC -> GPHT). A per-PC choice table (CPHT) selects between them.
//  The result is registered into ID. All tables train non-speculatively in MEM. Saturating
//  branch and mispredict counters are kept for performance evaluation.
// PARAMETERS
//  PC_LO        2    lowest PC bit used for all table indexing
//  BHT_IDX_W    10   log2 of local history table entries
//  LHIST_W      6    local history length; LPHT has 2^LHIST_W entries; legal range >=2
//  GHIST_W      8    GHR length; GPHT has 2^GHIST_W entries; legal range 2..(30-PC_LO)
//  CHOICE_IDX_W 8    log2 of CPHT entries
//  CTR_INIT     2'b10 reset value of every LPHT/GPHT counter (weakly taken)
//  CNT_W        32   width of the performance counters
// PORTS
//  clk           in  1        clock, rising edge
//  rst           in  1        synchronous, active-high reset
//  pcF           in  32       fetch PC
//  instrD        in  32       instruction in ID
//  stallD        in  1        hold the ID prediction register
//  flushD        in  1        clear the ID prediction register
//  pcM           in  32       PC of the instruction in MEM
//  branchM       in  1        MEM instruction is a conditional branch
//  actual_takeM  in  1        resolved direction in MEM
//  pred_takeM    in  1        prediction that was carried down the pipe for the MEM branch
//  branchD       out 1        ID instruction is a conditional branch (combinational)
//  pred_takeD    out 1        final prediction for the ID instruction
//  use_globalD   out 1        1 = the gshare component supplied pred_takeD
//  mispredM      out 1        branchM & (pred_takeM != actual_takeM) (combinational)
//  branch_cnt    out CNT_W    number of branches retired in MEM, saturating
//  mispred_cnt   out CNT_W    number of mispredicted branches, saturating
// BEHAVIOUR
//  Counters are 2-bit unsigned values: 00 SNT, 01 WNT, 10 WT, 11 ST. The prediction is bit[1].
//  Taken increments a counter and saturates at 11; not-taken decrements it and saturates at 00.
//  Decode rule for branchD:
//   - opcode instrD[31:26] in {000100 beq, 000101 bne, 000110 blez, 000111 bgtz}, OR
//   - opcode 000001 with rt[4:1] in {0000, 1000} (bltz/bgez/bltzal/bgezal).
//   - All other instructions, including j/jal/jr, give branchD = 0.
//  IF stage (combinational):
//   - lidx = pcF[PC_LO+:BHT_IDX_W]; lpred = LPHT[BHT[lidx]][1].
//   - gidx = GHR ^ pcF[PC_LO+:GHIST_W]; gpred = GPHT[gidx][1].
//   - cidx = pcF[PC_LO+:CHOICE_IDX_W]; sel = CPHT[cidx][1].
//   - predF = sel ? gpred : lpred.
//  F->D register {pred_r, sel_r}, updated on the clk edge:
//   - rst or flushD -> 0.
//   - else if stallD = 0 -> load {predF, sel}.
//   - else hold. Flush wins over stall.
//  Outputs: pred_takeD = branchD & pred_r; use_globalD = branchD & sel_r. Latency from pcF to ID is 1 cycle.
//  MEM update, only when branchM = 1 (no table or GHR change otherwise). Indices are recomputed
//  from pcM using the pre-edge table contents. All writes land at the same edge:
//   - BHT[lidxM] <= {lhistM[LHIST_W-2:0], actual_takeM}; GHR <= {GHR[GHIST_W-2:0], actual_takeM}.
//   - LPHT[lhistM] and GPHT[gidxM] each step toward actual_takeM.
//   - CPHT[cidxM] changes only if lpredM != gpredM: increment when gpredM == actual, decrement
//     when lpredM == actual.
//  Read/write collision: an IF read of an entry written at the same edge returns the old value.
//  Perf counters:
//   - branch_cnt increments on branchM.
//   - mispred_cnt increments on mispredM.
//   - Both hold at all-ones.
//  Reset values:
//   - BHT = 0, GHR = 0, LPHT/GPHT = CTR_INIT, CPHT = 2'b01 (weakly prefer local).
//   - Counters = 0; pred_takeD = use_globalD = 0.
//   - Reset mid-operation discards all training in one cycle.
// TESTING
//  T1 reset: rst for 1 cycle, then pcF=0x100 with beq in ID next cycle -> pred_takeD=1, use_globalD=0, counters 0.
//  T2 training: 2 MEM updates at pcM=0x100 with actual=0 -> LPHT[0]: 10->01->00, fetch 0x100 -> pred_takeD=0.
//  T3 stall/flush: pred_r=1, stallD=1 for 3 cycles -> pred_takeD stays 1; stallD=1 & flushD=1 -> 0 next cycle.
//  T4 pattern: alternating T/N branch at pc 0x40, 24 updates -> last 8 mispredM=0, branch_cnt=24.
//  T5 saturation: CNT_W=4, 20 mispredicted branches -> mispred_cnt=15, branch_cnt=15.
//  T6 decode: instr 0x04010000 (bgez) -> branchD=1; 0x04020000 -> 0; 0x08000000 (j) -> 0.

Source files
------------

// File: rtl/branch_predict_tournament.sv
// ---------------------------------------------------------------------------
// branch_predict_tournament
//
// Tournament branch predictor for the 5-stage MIPS pipeline.
//  - Local component : per-PC history (BHT) selects a 2-bit counter in LPHT.
//  - Global component: gshare, GHR xor PC selects a 2-bit counter in GPHT.
//  - Chooser         : per-PC 2-bit counter in CPHT, bit[1]=1 picks gshare.
// The prediction is formed in IF from pcF and registered into ID. All tables
// and the GHR are trained non-speculatively from the MEM-stage branch.
//
// Ports
//  clk, rst        clock (rising edge), synchronous active-high reset
//  pcF             fetch PC
//  instrD          instruction in ID (decoded for conditional branches)
//  stallD, flushD  hold / clear the ID prediction register (flush wins)
//  pcM, branchM    MEM-stage PC and conditional-branch flag
//  actual_takeM    resolved direction in MEM
//  pred_takeM      prediction carried down the pipe for the MEM branch
//  branchD         ID instruction is a conditional branch (combinational)
//  pred_takeD      final prediction for the ID instruction
//  use_globalD     gshare supplied pred_takeD
//  mispredM        MEM branch was mispredicted (combinational)
//  branch_cnt      retired branches, saturating
//  mispred_cnt     mispredicted branches, saturating
// ---------------------------------------------------------------------------
module branch_predict_tournament #(
  parameter int         PC_LO        = 2,
  parameter int         BHT_IDX_W    = 10,
  parameter int         LHIST_W      = 6,
  parameter int         GHIST_W      = 8,
  parameter int         CHOICE_IDX_W = 8,
  parameter logic [1:0] CTR_INIT     = 2'b10,
  parameter int         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcF,
  input  logic [31:0]      instrD,
  input  logic             stallD,
  input  logic             flushD,
  input  logic [31:0]      pcM,
  input  logic             branchM,
  input  logic             actual_takeM,
  input  logic             pred_takeM,
  output logic             branchD,
  output logic             pred_takeD,
  output logic             use_globalD,
  output logic             mispredM,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int BHT_N  = 1 << BHT_IDX_W;
  localparam int LPHT_N = 1 << LHIST_W;
  localparam int GPHT_N = 1 << GHIST_W;
  localparam int CPHT_N = 1 << CHOICE_IDX_W;

  // Two-bit saturating counter step: up saturates at 11, down at 00.
  function automatic logic [1:0] ctrStep(input logic [1:0] ctr, input logic up);
    logic [1:0] nxt;
    nxt = ctr;
    if (up) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
      else              nxt = ctr;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
      else              nxt = ctr;
    end
    return nxt;
  endfunction

  // Prediction tables and global history
  logic [LHIST_W-1:0] bht_r  [BHT_N];
  logic [1:0]         lpht_r [LPHT_N];
  logic [1:0]         gpht_r [GPHT_N];
  logic [1:0]         cpht_r [CPHT_N];
  logic [GHIST_W-1:0] ghr_r;

  // F->D prediction register
  logic pred_r;
  logic sel_r;

  // IF-stage lookup
  logic [BHT_IDX_W-1:0]    lidxF_s;
  logic [LHIST_W-1:0]      lhistF_s;
  logic [GHIST_W-1:0]      gidxF_s;
  logic [CHOICE_IDX_W-1:0] cidxF_s;
  logic                    lpredF_s;
  logic                    gpredF_s;
  logic                    selF_s;
  logic                    predF_s;

  // MEM-stage lookup (pre-edge table contents)
  logic [BHT_IDX_W-1:0]    lidxM_s;
  logic [LHIST_W-1:0]      lhistM_s;
  logic [GHIST_W-1:0]      gidxM_s;
  logic [CHOICE_IDX_W-1:0] cidxM_s;
  logic                    lpredM_s;
  logic                    gpredM_s;

  // Only part of the PCs and instruction feed the logic; fold the rest away.
  logic unusedBits_s;
  assign unusedBits_s = ^{pcF, pcM, instrD[25:21], instrD[16:0]};

  assign lidxF_s  = pcF[PC_LO +: BHT_IDX_W];
  assign lhistF_s = bht_r[lidxF_s];
  assign lpredF_s = lpht_r[lhistF_s][1];
  assign gidxF_s  = ghr_r ^ pcF[PC_LO +: GHIST_W];
  assign gpredF_s = gpht_r[gidxF_s][1];
  assign cidxF_s  = pcF[PC_LO +: CHOICE_IDX_W];
  assign selF_s   = cpht_r[cidxF_s][1];
  assign predF_s  = selF_s ? gpredF_s : lpredF_s;

  assign lidxM_s  = pcM[PC_LO +: BHT_IDX_W];
  assign lhistM_s = bht_r[lidxM_s];
  assign lpredM_s = lpht_r[lhistM_s][1];
  assign gidxM_s  = ghr_r ^ pcM[PC_LO +: GHIST_W];
  assign gpredM_s = gpht_r[gidxM_s][1];
  assign cidxM_s  = pcM[PC_LO +: CHOICE_IDX_W];

  // Conditional-branch decode of the ID instruction.
  always_comb begin
    branchD = 1'b0;
    case (instrD[31:26])
      6'b000100, 6'b000101, 6'b000110, 6'b000111: branchD = 1'b1;
      6'b000001: begin
        // REGIMM: only bltz/bgez/bltzal/bgezal (rt = 0,1,16,17)
        if ((instrD[20:17] == 4'b0000) || (instrD[20:17] == 4'b1000)) branchD = 1'b1;
        else                                                          branchD = 1'b0;
      end
      default: branchD = 1'b0;
    endcase
  end

  assign pred_takeD  = branchD & pred_r;
  assign use_globalD = branchD & sel_r;
  assign mispredM    = branchM & (pred_takeM != actual_takeM);

  // F->D prediction register; flush has priority over stall.
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      pred_r <= 1'b0;
      sel_r  <= 1'b0;
    end else if (!stallD) begin
      pred_r <= predF_s;
      sel_r  <= selF_s;
    end else begin
      pred_r <= pred_r;
      sel_r  <= sel_r;
    end
  end

  // Local history table: shift the resolved direction into the branch's history.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht_r[i] <= '0;
    end else if (branchM) begin
      bht_r[lidxM_s] <= {lhistM_s[LHIST_W-2:0], actual_takeM};
    end
  end

  // Global history register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_r <= '0;
    end else if (branchM) begin
      ghr_r <= {ghr_r[GHIST_W-2:0], actual_takeM};
    end
  end

  // Local pattern table, indexed by the pre-update local history.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LPHT_N; i++) lpht_r[i] <= CTR_INIT;
    end else if (branchM) begin
      lpht_r[lhistM_s] <= ctrStep(lpht_r[lhistM_s], actual_takeM);
    end
  end

  // Gshare pattern table, indexed by the pre-update GHR.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GPHT_N; i++) gpht_r[i] <= CTR_INIT;
    end else if (branchM) begin
      gpht_r[gidxM_s] <= ctrStep(gpht_r[gidxM_s], actual_takeM);
    end
  end

  // Chooser: moves only on disagreement, toward whichever component was right.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CPHT_N; i++) cpht_r[i] <= 2'b01;
    end else if (branchM && (lpredM_s != gpredM_s)) begin
      cpht_r[cidxM_s] <= ctrStep(cpht_r[cidxM_s], gpredM_s == actual_takeM);
    end
  end

  // Saturating retired-branch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt <= '0;
    end else if (branchM && (branch_cnt != {CNT_W{1'b1}})) begin
      branch_cnt <= branch_cnt + CNT_W'(1);
    end
  end

  // Saturating mispredict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispred_cnt <= '0;
    end else if (mispredM && (mispred_cnt != {CNT_W{1'b1}})) begin
      mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_tournament.sv
module tb_branch_predict_tournament;

  logic        clk = 1'b0;
  logic        rst, stallD, flushD, branchM, actual_takeM, pred_takeM;
  logic [31:0] pcF, instrD, pcM;
  logic        branchD, pred_takeD, use_globalD, mispredM;
  logic [31:0] branch_cnt, mispred_cnt;
  logic        sBranchD, sPredTakeD, sUseGlobalD, sMispredM;
  logic [3:0]  sBranchCnt, sMispredCnt;

  always #5 clk = ~clk;

  branch_predict_tournament dut (
    .clk(clk), .rst(rst), .pcF(pcF), .instrD(instrD), .stallD(stallD), .flushD(flushD),
    .pcM(pcM), .branchM(branchM), .actual_takeM(actual_takeM), .pred_takeM(pred_takeM),
    .branchD(branchD), .pred_takeD(pred_takeD), .use_globalD(use_globalD),
    .mispredM(mispredM), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predict_tournament #(.CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .pcF(pcF), .instrD(instrD), .stallD(stallD), .flushD(flushD),
    .pcM(pcM), .branchM(branchM), .actual_takeM(actual_takeM), .pred_takeM(pred_takeM),
    .branchD(sBranchD), .pred_takeD(sPredTakeD), .use_globalD(sUseGlobalD),
    .mispredM(sMispredM), .branch_cnt(sBranchCnt), .mispred_cnt(sMispredCnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int     bht [1024];
  int     lpht[64];
  int     gpht[256];
  int     cpht[256];
  int     ghr;
  bit     mPred, mSel;
  longint brCnt, mpCnt, brCntS, mpCntS;

  function automatic int sat2(input int v);
    return (v < 0) ? 0 : ((v > 3) ? 3 : v);
  endfunction

  function automatic bit isBranch(input logic [31:0] ins);
    int op, rt;
    op = int'(ins >> 26);
    rt = int'((ins >> 16) & 32'd31);
    if (op >= 4 && op <= 7) return 1'b1;
    if (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void modelPredict(input logic [31:0] pc, output bit p, output bit s);
    int w;
    bit lp, gp;
    w  = int'(pc >> 2);
    lp = lpht[bht[w % 1024]] >= 2;
    gp = gpht[ghr ^ (w % 256)] >= 2;
    s  = cpht[w % 256] >= 2;
    p  = s ? gp : lp;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 1024; i++) bht[i] = 0;
    for (int i = 0; i < 64; i++)   lpht[i] = 2;
    for (int i = 0; i < 256; i++)  begin gpht[i] = 2; cpht[i] = 1; end
    ghr = 0; mPred = 0; mSel = 0;
    brCnt = 0; mpCnt = 0; brCntS = 0; mpCntS = 0;
  endfunction

  function automatic void modelEdge();
    bit p, s, lp, gp, a;
    int w, li, lh, gi, ci;
    if (rst) begin
      modelReset();
    end else begin
      modelPredict(pcF, p, s);
      if (flushD) begin mPred = 0; mSel = 0; end
      else if (!stallD) begin mPred = p; mSel = s; end
      if (branchM) begin
        a  = actual_takeM;
        w  = int'(pcM >> 2);
        li = w % 1024; lh = bht[li]; gi = ghr ^ (w % 256); ci = w % 256;
        lp = lpht[lh] >= 2; gp = gpht[gi] >= 2;
        if (lp != gp) cpht[ci] = sat2(cpht[ci] + ((gp == a) ? 1 : -1));
        lpht[lh] = sat2(lpht[lh] + (a ? 1 : -1));
        gpht[gi] = sat2(gpht[gi] + (a ? 1 : -1));
        bht[li]  = (lh * 2 + int'(a)) % 64;
        ghr      = (ghr * 2 + int'(a)) % 256;
        brCnt++;
        if (brCntS < 15) brCntS++;
        if (pred_takeM != a) begin
          mpCnt++;
          if (mpCntS < 15) mpCntS++;
        end
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic setIdle();
    rst = 1'b0; stallD = 1'b0; flushD = 1'b0; branchM = 1'b0;
    actual_takeM = 1'b0; pred_takeM = 1'b0;
    pcF = 32'h0; pcM = 32'h0; instrD = 32'h1000_0000;
  endtask

  task automatic checkAll();
    bit b;
    b = isBranch(instrD);
    checkVal("branchD", {63'd0, branchD}, {63'd0, b});
    checkVal("pred_takeD", {63'd0, pred_takeD}, {63'd0, b & mPred});
    checkVal("use_globalD", {63'd0, use_globalD}, {63'd0, b & mSel});
    checkVal("mispredM", {63'd0, mispredM}, {63'd0, branchM && (pred_takeM != actual_takeM)});
    checkVal("branch_cnt", {32'd0, branch_cnt}, brCnt);
    checkVal("mispred_cnt", {32'd0, mispred_cnt}, mpCnt);
    checkVal("sat pred_takeD", {63'd0, sPredTakeD}, {63'd0, b & mPred});
    checkVal("sat branch_cnt", {60'd0, sBranchCnt}, brCntS);
    checkVal("sat mispred_cnt", {60'd0, sMispredCnt}, mpCntS);
  endtask

  task automatic step();
    @(negedge clk);
    checkAll();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic resetStep();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p, s;
    logic [31:0] r;
    int sel;

    setIdle();
    rst = 1'b1;
    @(posedge clk);
    modelEdge();
    #1;

    // T1: reset state, then first beq fetch predicts weakly taken via local
    rst = 1'b0; pcF = 32'h100; instrD = 32'h1000_0000;
    step();
    checkVal("T1 pred_takeD", {63'd0, pred_takeD}, 64'd1);
    checkVal("T1 use_globalD", {63'd0, use_globalD}, 64'd0);
    checkVal("T1 branch_cnt", {32'd0, branch_cnt}, 64'd0);
    checkVal("T1 mispred_cnt", {32'd0, mispred_cnt}, 64'd0);

    // T2: two not-taken updates at 0x100 drive LPHT[0] to 00
    branchM = 1'b1; pcM = 32'h100; actual_takeM = 1'b0; pred_takeM = 1'b1;
    step(); step();
    branchM = 1'b0;
    step();
    checkVal("T2 pred_takeD", {63'd0, pred_takeD}, 64'd0);

    // T3: stall holds a taken prediction, flush beats stall
    resetStep();
    pcF = 32'h300;
    step();
    checkVal("T3 load", {63'd0, pred_takeD}, 64'd1);
    stallD = 1'b1; pcF = 32'h100;
    branchM = 1'b1; pcM = 32'h100; actual_takeM = 1'b0; pred_takeM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("T3 stall hold", {63'd0, pred_takeD}, 64'd1);
    end
    flushD = 1'b1;
    step();
    checkVal("T3 flush", {63'd0, pred_takeD}, 64'd0);
    setIdle();

    // T4: alternating branch at 0x40 is learned
    resetStep();
    for (int k = 0; k < 24; k++) begin
      pcF = 32'h40; pcM = 32'h40; branchM = 1'b1;
      actual_takeM = (k % 2 == 0);
      modelPredict(32'h40, p, s);
      pred_takeM = p;
      #1;
      if (k >= 16) checkVal("T4 mispredM", {63'd0, mispredM}, 64'd0);
      step();
    end
    branchM = 1'b0;
    step();
    checkVal("T4 branch_cnt", {32'd0, branch_cnt}, 64'd24);

    // T5: counter saturation on the 4-bit instance
    resetStep();
    for (int k = 0; k < 20; k++) begin
      branchM = 1'b1;
      actual_takeM = 1'($urandom % 2);
      pred_takeM = ~actual_takeM;
      pcM = $urandom & 32'h0000_0FFC;
      step();
    end
    branchM = 1'b0;
    step();
    checkVal("T5 sat mispred_cnt", {60'd0, sMispredCnt}, 64'd15);
    checkVal("T5 sat branch_cnt", {60'd0, sBranchCnt}, 64'd15);
    checkVal("T5 wide mispred_cnt", {32'd0, mispred_cnt}, 64'd20);

    // T6: decode corner cases
    instrD = 32'h0401_0000; #1;
    checkVal("T6 bgez", {63'd0, branchD}, 64'd1);
    instrD = 32'h0402_0000; #1;
    checkVal("T6 regimm rt2", {63'd0, branchD}, 64'd0);
    instrD = 32'h0800_0000; #1;
    checkVal("T6 j", {63'd0, branchD}, 64'd0);
    instrD = 32'h0411_0000; #1;
    checkVal("T6 bgezal", {63'd0, branchD}, 64'd1);
    instrD = 32'h1C00_0000; #1;
    checkVal("T6 bgtz", {63'd0, branchD}, 64'd1);

    // Randomized traffic with aliasing PCs, stalls, flushes and resets
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom % 64) == 0;
      stallD = ($urandom % 4) == 0;
      flushD = ($urandom % 8) == 0;
      pcF = (32'($urandom_range(0, 31)) << 2) | (32'($urandom % 2) << 12);
      pcM = (32'($urandom_range(0, 31)) << 2) | (32'($urandom % 2) << 12);
      r = $urandom;
      sel = int'($urandom % 4);
      if (sel == 1) r[31:26] = 6'($urandom_range(4, 7));
      if (sel == 2) r[31:26] = 6'd1;
      if (sel == 3) r[31:26] = 6'd2;
      instrD = r;
      branchM = 1'($urandom % 2);
      actual_takeM = 1'($urandom % 2);
      modelPredict(pcM, p, s);
      pred_takeM = (($urandom % 4) == 0) ? 1'($urandom % 2) : p;
      step();
    end
    setIdle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
